// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the execute-stage operand mux.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

   // Register-file address width (x0..x31)
   localparam int REG_AW = 5;

   // Controller states
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_t;

   // Operand source select encodings, also decoded by the EX operand mux
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // A producer hits a source operand when it writes the same, non-zero register
   function automatic logic reg_hit(
      input logic [REG_AW-1:0] rs_addr,
      input logic [REG_AW-1:0] rd_addr,
      input logic              rd_write
   );
      return rd_write && (rs_addr == rd_addr) && (rs_addr != '0);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_sel.sv
// Operand forwarding select for one EX-stage ALU operand.
// Latency: zero, purely combinational.
// Backpressure: none; follows the pipeline registers it observes.
module pipeline_ctrl_forward_sel
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] i_rs_addr,
   input  logic [REG_AW-1:0] i_ex_dstreg_addr,
   input  logic              i_ex_write_reg,
   input  logic              i_ex_is_load,
   input  logic [REG_AW-1:0] i_mem_dstreg_addr,
   input  logic              i_mem_write_reg,
   output logic [1:0]        o_sel
);

   // Youngest producer wins; a load in EX has no data yet, so it cannot forward
   always_comb begin
      o_sel = FWD_REG;
      if (reg_hit(i_rs_addr, i_ex_dstreg_addr, i_ex_write_reg) && !i_ex_is_load) begin
         o_sel = FWD_EX;
      end else if (reg_hit(i_rs_addr, i_mem_dstreg_addr, i_mem_write_reg)) begin
         o_sel = FWD_MEM;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing control for the 5-stage core: forwarding, load-use bubbles, branch flush, MDU hold.
// Latency: all controls combinational (same cycle); MDU wait state and counters are registered.
// Backpressure: holds IF/ID (and ID/EX during MUL/DIV) until the hazard clears or mdu_done arrives.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MDU_MAX_CYCLES = 34,
   parameter int CNT_W          = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [REG_AW-1:0] i_id_rs1_addr,
   input  logic [REG_AW-1:0] i_id_rs2_addr,
   input  logic              i_id_uses_rs1,
   input  logic              i_id_uses_rs2,
   input  logic [REG_AW-1:0] i_ex_dstreg_addr,
   input  logic              i_ex_write_reg,
   input  logic              i_ex_is_load,
   input  logic              i_ex_mdu_op,
   input  logic              i_ex_branch_taken,
   input  logic [REG_AW-1:0] i_mem_dstreg_addr,
   input  logic              i_mem_write_reg,
   input  logic              i_mdu_done,
   output logic [1:0]        o_fwd_a_sel,
   output logic [1:0]        o_fwd_b_sel,
   output logic              o_stall_if,
   output logic              o_stall_id,
   output logic              o_stall_ex,
   output logic              o_flush_id,
   output logic              o_flush_ex,
   output logic              o_mdu_start,
   output logic              o_mdu_timeout,
   output logic [CNT_W-1:0]  o_stall_cycles
);

   // Wait counter only needs to reach MDU_MAX_CYCLES, where it saturates
   localparam int              WC_W   = $clog2(MDU_MAX_CYCLES + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MDU_MAX_CYCLES);
   localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

   state_t           r_state;
   logic [WC_W-1:0]  r_wait_cnt;
   logic             r_timeout;
   logic [CNT_W-1:0] r_stall_cnt;

   logic            w_run;
   logic            w_load_use;
   logic            w_branch;
   logic            w_start;
   logic            w_lu_bubble;
   logic            w_wait_hold;
   logic [WC_W-1:0] w_cnt_inc;

   pipeline_ctrl_forward_sel u_fwd_a (
      .i_rs_addr         (i_id_rs1_addr),
      .i_ex_dstreg_addr  (i_ex_dstreg_addr),
      .i_ex_write_reg    (i_ex_write_reg),
      .i_ex_is_load      (i_ex_is_load),
      .i_mem_dstreg_addr (i_mem_dstreg_addr),
      .i_mem_write_reg   (i_mem_write_reg),
      .o_sel             (o_fwd_a_sel)
   );

   pipeline_ctrl_forward_sel u_fwd_b (
      .i_rs_addr         (i_id_rs2_addr),
      .i_ex_dstreg_addr  (i_ex_dstreg_addr),
      .i_ex_write_reg    (i_ex_write_reg),
      .i_ex_is_load      (i_ex_is_load),
      .i_mem_dstreg_addr (i_mem_dstreg_addr),
      .i_mem_write_reg   (i_mem_write_reg),
      .o_sel             (o_fwd_b_sel)
   );

   // Hazard decode with RUN-state priority branch > MDU > load-use
   always_comb begin
      w_run       = (r_state == ST_RUN);
      w_load_use  = i_ex_is_load && i_ex_write_reg && (i_ex_dstreg_addr != '0) &&
                    ((i_id_uses_rs1 && (i_id_rs1_addr == i_ex_dstreg_addr)) ||
                     (i_id_uses_rs2 && (i_id_rs2_addr == i_ex_dstreg_addr)));
      w_branch    = w_run && i_ex_branch_taken;
      w_start     = w_run && !i_ex_branch_taken && i_ex_mdu_op;
      w_lu_bubble = w_run && !i_ex_branch_taken && !i_ex_mdu_op && w_load_use;
      // mdu_done releases the hold in the very cycle it arrives
      w_wait_hold = (r_state == ST_MDU_WAIT) && !i_mdu_done;
      w_cnt_inc   = (r_wait_cnt == WC_MAX) ? r_wait_cnt : r_wait_cnt + WC_ONE;
   end

   // Controls are gated by reset so they drop immediately, even with an MDU op still in EX
   always_comb begin
      o_stall_if     = i_rst_n && (w_start || w_wait_hold || w_lu_bubble);
      o_stall_id     = i_rst_n && (w_start || w_wait_hold || w_lu_bubble);
      o_stall_ex     = i_rst_n && (w_start || w_wait_hold);
      o_flush_id     = i_rst_n && w_branch;
      o_flush_ex     = i_rst_n && (w_branch || w_lu_bubble);
      o_mdu_start    = i_rst_n && w_start;
      o_mdu_timeout  = r_timeout;
      o_stall_cycles = r_stall_cnt;
   end

   // RUN/MDU_WAIT sequencing with saturating wait counter and sticky timeout
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_start) begin
                  r_state    <= ST_MDU_WAIT;
                  r_wait_cnt <= WC_ONE;
                  if (WC_ONE >= WC_MAX) begin
                     r_timeout <= 1'b1;
                  end
               end
            end
            ST_MDU_WAIT: begin
               if (i_mdu_done) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= '0;
               end else begin
                  r_wait_cnt <= w_cnt_inc;
                  if (w_cnt_inc == WC_MAX) begin
                     r_timeout <= 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= ST_RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   // Performance counter of PC-hold cycles, wraps naturally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (o_stall_if) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: vector table for combinational decode,
// hand sequences for load-use follow-up, MDU hold, reset mid-MDU and timeout.
// Two instances: default parameters, and MDU_MAX_CYCLES=4 for the timeout sequence.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, exd, memd;
   logic       u1, u2, exw, exld, exmdu, br, memw, done;

   logic [1:0]  fa, fb;
   logic        sif, sid, sex, fid, fex, ms, tmo;
   logic [31:0] scnt;

   logic [1:0]  d2_fa, d2_fb;
   logic        d2_sif, d2_sid, d2_sex, d2_fid, d2_fex, d2_ms, d2_tmo;
   logic [31:0] d2_scnt;

   logic [9:0] w_out;
   assign w_out = {fa, fb, sif, sid, sex, fid, fex, ms};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MDU_MAX_CYCLES(34), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
      .i_ex_dstreg_addr(exd), .i_ex_write_reg(exw), .i_ex_is_load(exld), .i_ex_mdu_op(exmdu),
      .i_ex_branch_taken(br), .i_mem_dstreg_addr(memd), .i_mem_write_reg(memw), .i_mdu_done(done),
      .o_fwd_a_sel(fa), .o_fwd_b_sel(fb), .o_stall_if(sif), .o_stall_id(sid), .o_stall_ex(sex),
      .o_flush_id(fid), .o_flush_ex(fex), .o_mdu_start(ms), .o_mdu_timeout(tmo),
      .o_stall_cycles(scnt)
   );

   pipeline_ctrl #(.MDU_MAX_CYCLES(4), .CNT_W(32)) dut_to (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
      .i_ex_dstreg_addr(exd), .i_ex_write_reg(exw), .i_ex_is_load(exld), .i_ex_mdu_op(exmdu),
      .i_ex_branch_taken(br), .i_mem_dstreg_addr(memd), .i_mem_write_reg(memw), .i_mdu_done(done),
      .o_fwd_a_sel(d2_fa), .o_fwd_b_sel(d2_fb), .o_stall_if(d2_sif), .o_stall_id(d2_sid),
      .o_stall_ex(d2_sex), .o_flush_id(d2_fid), .o_flush_ex(d2_fex), .o_mdu_start(d2_ms),
      .o_mdu_timeout(d2_tmo), .o_stall_cycles(d2_scnt)
   );

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] exd;
      logic       exw, exld, exmdu, br;
      logic [4:0] memd;
      logic       memw;
      logic [9:0] exp; // {fwd_a, fwd_b, stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_start}
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic addv(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                       input logic f1, input logic f2, input logic [4:0] ed, input logic ew,
                       input logic el, input logic em, input logic eb, input logic [4:0] md,
                       input logic mw, input logic [9:0] ex);
      vec_t v;
      v.name = nm; v.rs1 = a1; v.rs2 = a2; v.u1 = f1; v.u2 = f2;
      v.exd = ed; v.exw = ew; v.exld = el; v.exmdu = em; v.br = eb;
      v.memd = md; v.memw = mw; v.exp = ex;
      vq.push_back(v);
   endtask

   task automatic idle();
      rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
      exd = 5'd0; exw = 1'b0; exld = 1'b0; exmdu = 1'b0; br = 1'b0;
      memd = 5'd0; memw = 1'b0; done = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] cnt0;
      int n_ms, n_st;

      //   name                rs1    rs2    u1 u2 exd    w  ld mdu br memd   mw  fa fb sif sid sex fid fex ms
      addv("idle",             5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 0,  0, 5'd0,  0, 10'b00_00_000000);
      addv("fwd_ex_over_mem",  5'd5,  5'd0,  1, 0, 5'd5,  1, 0, 0,  0, 5'd5,  1, 10'b01_00_000000);
      addv("fwd_x0_never",     5'd0,  5'd0,  1, 1, 5'd0,  1, 0, 0,  0, 5'd0,  1, 10'b00_00_000000);
      addv("fwd_mem_rs2",      5'd0,  5'd9,  0, 1, 5'd3,  1, 0, 0,  0, 5'd9,  1, 10'b00_10_000000);
      addv("fwd_no_write",     5'd4,  5'd4,  1, 1, 5'd4,  0, 0, 0,  0, 5'd4,  0, 10'b00_00_000000);
      addv("load_rs_unused",   5'd7,  5'd0,  0, 0, 5'd7,  1, 1, 0,  0, 5'd0,  0, 10'b00_00_000000);
      addv("load_use_rs1",     5'd7,  5'd2,  1, 1, 5'd7,  1, 1, 0,  0, 5'd0,  0, 10'b00_00_110010);
      addv("load_use_rs2",     5'd3,  5'd8,  1, 1, 5'd8,  1, 1, 0,  0, 5'd3,  1, 10'b10_00_110010);
      addv("load_x0",          5'd0,  5'd0,  1, 1, 5'd0,  1, 1, 0,  0, 5'd0,  0, 10'b00_00_000000);
      addv("load_no_write",    5'd7,  5'd0,  1, 0, 5'd7,  0, 1, 0,  0, 5'd0,  0, 10'b00_00_000000);
      addv("branch_over_lu",   5'd7,  5'd0,  1, 0, 5'd7,  1, 1, 0,  1, 5'd0,  0, 10'b00_00_000110);
      addv("branch_over_mdu",  5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 1,  1, 5'd0,  0, 10'b00_00_000110);
      addv("branch_fwd_both",  5'd6,  5'd6,  1, 1, 5'd6,  1, 0, 0,  1, 5'd0,  0, 10'b01_01_000110);

      idle();
      rst_n = 1'b0;
      #1;
      // Reset state
      chk("reset_ctrl", 32'(w_out[5:0]), 32'd0);
      chk("reset_timeout", 32'(tmo), 32'd0);
      chk("reset_stall_cycles", scnt, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Vector table; the two load-use entries each add one stall cycle
      cnt0 = scnt;
      foreach (vq[i]) begin
         @(negedge clk);
         rs1 = vq[i].rs1; rs2 = vq[i].rs2; u1 = vq[i].u1; u2 = vq[i].u2;
         exd = vq[i].exd; exw = vq[i].exw; exld = vq[i].exld; exmdu = vq[i].exmdu;
         br = vq[i].br; memd = vq[i].memd; memw = vq[i].memw; done = 1'b0;
         #1;
         chk(vq[i].name, 32'(w_out), 32'(vq[i].exp));
      end
      @(negedge clk);
      idle();
      #1;
      chk("table_stall_cycles", scnt - cnt0, 32'd2);

      // Load-use then the load moves to MEM and is forwarded from there
      @(negedge clk);
      rs1 = 5'd7; u1 = 1'b1; rs2 = 5'd2; u2 = 1'b1; exd = 5'd7; exw = 1'b1; exld = 1'b1;
      #1;
      chk("lu_seq_bubble", 32'({sif, sid, fex, fid}), 32'b1110);
      @(negedge clk);
      exd = 5'd0; exw = 1'b0; exld = 1'b0; memd = 5'd7; memw = 1'b1;
      #1;
      chk("lu_seq_fwd_mem", 32'({fa, sif}), 32'b100);

      // mdu_done while in RUN does nothing
      @(negedge clk);
      idle();
      done = 1'b1;
      #1;
      chk("done_in_run", 32'(w_out[5:0]), 32'd0);
      @(negedge clk);
      done = 1'b0;
      #1;
      chk("done_in_run_after", 32'(w_out[5:0]), 32'd0);

      // MDU op completing after 33 stalled cycles (done arrives in the 34th)
      cnt0 = scnt; n_ms = 0; n_st = 0;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         if (c == 1) begin
            exmdu = 1'b1; exd = 5'd10; exw = 1'b1;
         end
         done = (c == 34);
         #1;
         if (ms) n_ms++;
         if (sif && sid && sex) n_st++;
         if (c == 1) chk("mdu_start_first", 32'({ms, sif, sid, sex}), 32'b1111);
         if (c == 2) chk("mdu_no_restart", 32'({ms, sif}), 32'b01);
         if (c == 34) chk("mdu_done_release", 32'({sif, sid, sex, ms}), 32'd0);
      end
      chk("mdu_start_pulses", 32'(n_ms), 32'd1);
      chk("mdu_stalled_cycles", 32'(n_st), 32'd33);
      chk("mdu_stall_cnt_delta", scnt - cnt0, 32'd33);
      chk("mdu_no_timeout", 32'(tmo), 32'd0);
      @(negedge clk);
      idle();
      #1;
      chk("mdu_back_to_run", 32'({sif, sex}), 32'd0);

      // Asynchronous reset in the middle of an MDU wait
      @(negedge clk);
      exmdu = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mdu_ctrl", 32'({sif, sid, sex, fid, fex, ms, tmo}), 32'd0);
      chk("rst_mid_mdu_cnt", scnt, 32'd0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_mid_mdu_run", 32'({sif, sid, sex}), 32'd0);

      // Timeout with MDU_MAX_CYCLES=4: flagged after the 4th stalled cycle, sticky
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1) exmdu = 1'b1;
         done = (c == 9);
         #1;
         chk($sformatf("timeout_c%0d", c), 32'(d2_tmo), (c >= 5) ? 32'd1 : 32'd0);
         chk($sformatf("timeout_stall_c%0d", c), 32'(d2_sif), (c <= 8) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("timeout_sticky", 32'({d2_tmo, d2_sif}), 32'b10);
      chk("timeout_stall_cnt", d2_scnt, 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
